// File: rtl/sync_sipo_deser_pkg.sv
// Shared constants for the SIPO deserializer and its PISO-side bench.
package sync_sipo_deser_pkg;

   // FSM encodings, kept as plain constants for legacy compatibility
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   // Width of a counter that must hold 0..w
   function automatic int unsigned cnt_w(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/sync_sipo_deser_if.sv
// Serial input, parallel output handshake and status bundle of the deserializer.
interface sync_sipo_deser_if
   import sync_sipo_deser_pkg::*;
#(
   parameter int unsigned W = 4
);

   logic                  in;
   logic                  in_valid;
   logic                  start;
   logic [W-1:0]          out;
   logic                  out_valid;
   logic                  out_ready;
   logic                  busy;
   logic [cnt_w(W)-1:0]   bit_cnt;
   logic                  overrun;
   logic                  frame_err;
   logic                  clr_ovr;

   // Environment side: drives the serial link and consumes words
   modport master (
      output in, in_valid, start, out_ready, clr_ovr,
      input  out, out_valid, busy, bit_cnt, overrun, frame_err
   );

   // Deserializer side
   modport slave (
      input  in, in_valid, start, out_ready, clr_ovr,
      output out, out_valid, busy, bit_cnt, overrun, frame_err
   );

endinterface

// File: rtl/sync_sipo_deser_bit_counter.sv
// Frame bit counter: load-1 on frame start, increment per bit, clear on completion.
module sync_sipo_deser_bit_counter
   import sync_sipo_deser_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load1,
   input  logic                  inc,
   input  logic                  clr,
   output logic [cnt_w(W)-1:0]   cnt,
   output logic                  term
);

   localparam int unsigned CW = cnt_w(W);

   // Restart has priority so an aborting start always becomes bit 0 of a new frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       cnt <= '0;
      else if (load1) cnt <= CW'(1);
      else if (clr)   cnt <= '0;
      else if (inc)   cnt <= cnt + CW'(1);
   end

   // Next captured bit is the last one of the frame
   always_comb term = (cnt == CW'(W - 1));

endmodule

// File: rtl/sync_sipo_deser.sv
// Serial-in parallel-out deserializer with 1-entry held output buffer.
module sync_sipo_deser
   import sync_sipo_deser_pkg::*;
#(
   parameter int unsigned W         = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic              clk,
   input logic              rst,
   sync_sipo_deser_if.slave bus
);

   logic         state_q, state_d;
   logic [W-1:0] sr_q, sr_d, base;
   logic [W-1:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic         overrun_q, overrun_d;
   logic         frame_err_q, frame_err_d;
   logic         restart, cap, done, term;

   sync_sipo_deser_bit_counter #(.W(W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .load1 (restart),
      .inc   (cap & ~restart & ~done),
      .clr   (done),
      .cnt   (bus.bit_cnt),
      .term  (term)
   );

   // Frame control, shift path and output buffer next state
   always_comb begin
      restart     = bus.in_valid & bus.start;
      cap         = bus.in_valid & (bus.start | (state_q == ST_SHIFT));
      done        = bus.in_valid & ~bus.start & (state_q == ST_SHIFT) & term;
      frame_err_d = restart & (state_q == ST_SHIFT);

      state_d = state_q;
      if (restart)   state_d = ST_SHIFT;
      else if (done) state_d = ST_IDLE;

      // A fresh frame starts from zero so no stale bits leak into it
      base = bus.start ? '0 : sr_q;
      sr_d = sr_q;
      if (cap) begin
         if (MSB_FIRST) sr_d = {base[W-2:0], bus.in};
         else           sr_d = {bus.in, base[W-1:1]};
      end

      out_d       = out_q;
      out_valid_d = out_valid_q;
      overrun_d   = clr_ovr_eff(overrun_q, bus.clr_ovr);
      if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
      if (done) begin
         if (!out_valid_q || bus.out_ready) begin
            out_d       = sr_d;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;  // set beats a same-edge clear
         end
      end
   end

   function automatic logic clr_ovr_eff(input logic ovr, input logic clr);
      return clr ? 1'b0 : ovr;
   endfunction

   // State, shift register and output buffer registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Registered values onto the bus
   always_comb begin
      bus.out       = out_q;
      bus.out_valid = out_valid_q;
      bus.busy      = (state_q == ST_SHIFT);
      bus.overrun   = overrun_q;
      bus.frame_err = frame_err_q;
   end

endmodule
